// File: rtl/sad_stream_engine.sv
// Streaming sum-of-absolute-differences engine: one SAD per BLK-element block, NBLK blocks per frame.
// Optional SAD_MINTRACK_EN adds Min_SAD/Min_Idx tracking of the smallest block SAD.
module sad_stream_engine #(
  parameter int DW      = 8,
  parameter int AW      = 15,
  parameter int BLK     = 256,
  parameter int NBLK    = 128,
  parameter int CW      = 7,
  parameter int SW      = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          Go,
  input  logic          Abort,
  output logic [AW-1:0] A_Addr,
  output logic [AW-1:0] B_Addr,
  input  logic [DW-1:0] A_Data,
  input  logic [DW-1:0] B_Data,
  output logic          I_En,
  output logic          I_RW,
  output logic [CW-1:0] C_Addr,
  output logic          O_En,
  output logic          O_RW,
  output logic [SW-1:0] SAD_Out,
  output logic          Busy,
  output logic          Done
`ifdef SAD_MINTRACK_EN
  ,
  output logic [SW-1:0] Min_SAD,
  output logic [CW-1:0] Min_Idx
`endif
);

  localparam int JW = (BLK > 1) ? $clog2(BLK) : 1;
  localparam logic [JW-1:0] J_LAST = JW'(BLK - 1);
  localparam logic [1:0]    L_LAST = 2'(MEM_LAT - 1);
  localparam logic [CW-1:0] B_LAST = CW'(NBLK - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t              state_r, state_nx_s;
  logic [JW-1:0]       j_r, j_nx_s;
  logic [AW-1:0]       base_r, base_nx_s;
  logic [CW-1:0]       blk_r, blk_nx_s;
  logic [1:0]          lat_r, lat_nx_s;
  logic [SW-1:0]       sum_r, sum_nx_s;
  logic [MEM_LAT-1:0]  vpipe_r;
  logic [DW-1:0]       diff_s;
  logic                abort_s;
  logic                issue_nx_s;
  logic                write_nx_s;

  // Absolute difference of the returning operand pair, tap of the valid pipe
  always_comb begin
    diff_s  = (A_Data >= B_Data) ? (A_Data - B_Data) : (B_Data - A_Data);
    abort_s = Abort && (state_r != S_IDLE);
  end

  // Next-state, counter and accumulator logic
  always_comb begin
    state_nx_s = state_r;
    j_nx_s     = j_r;
    base_nx_s  = base_r;
    blk_nx_s   = blk_r;
    lat_nx_s   = lat_r;
    sum_nx_s   = sum_r;
    if (abort_s) begin
      state_nx_s = S_IDLE;
      j_nx_s     = '0;
      lat_nx_s   = '0;
      sum_nx_s   = '0;
    end else begin
      if (vpipe_r[MEM_LAT-1]) begin
        sum_nx_s = sum_r + SW'(diff_s);
      end else begin
        sum_nx_s = sum_r;
      end
      case (state_r)
        S_IDLE: begin
          if (Go) begin
            state_nx_s = S_ISSUE;
            j_nx_s     = '0;
            base_nx_s  = '0;
            blk_nx_s   = '0;
            sum_nx_s   = '0;
          end else begin
            state_nx_s = S_IDLE;
          end
        end
        S_ISSUE: begin
          if (j_r == J_LAST) begin
            state_nx_s = S_DRAIN;
            j_nx_s     = '0;
            lat_nx_s   = '0;
          end else begin
            j_nx_s = j_r + 1'b1;
          end
        end
        S_DRAIN: begin
          if (lat_r == L_LAST) begin
            state_nx_s = S_WRITE;
          end else begin
            lat_nx_s = lat_r + 2'd1;
          end
        end
        S_WRITE: begin
          sum_nx_s  = '0;
          base_nx_s = base_r + AW'(BLK);
          blk_nx_s  = blk_r + 1'b1;
          if (blk_r == B_LAST) begin
            state_nx_s = S_FIN;
          end else begin
            state_nx_s = S_ISSUE;
          end
        end
        S_FIN: begin
          state_nx_s = S_IDLE;
        end
        default: begin
          state_nx_s = S_IDLE;
        end
      endcase
    end
    issue_nx_s = (state_nx_s == S_ISSUE);
    write_nx_s = (state_nx_s == S_WRITE);
  end

  // State, counters and outputs; outputs are loaded from next-state values so they align with the state
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r <= S_IDLE;
      j_r     <= '0;
      base_r  <= '0;
      blk_r   <= '0;
      lat_r   <= '0;
      sum_r   <= '0;
      vpipe_r <= '0;
      A_Addr  <= '0;
      B_Addr  <= '0;
      I_En    <= 1'b0;
      I_RW    <= 1'b0;
      C_Addr  <= '0;
      O_En    <= 1'b0;
      O_RW    <= 1'b0;
      SAD_Out <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      j_r     <= j_nx_s;
      base_r  <= base_nx_s;
      blk_r   <= blk_nx_s;
      lat_r   <= lat_nx_s;
      sum_r   <= sum_nx_s;
      if (abort_s) begin
        vpipe_r <= '0;
      end else begin
        vpipe_r[0] <= I_En;
        for (int i = 1; i < MEM_LAT; i++) begin
          vpipe_r[i] <= vpipe_r[i-1];
        end
      end
      A_Addr  <= issue_nx_s ? (base_nx_s + AW'(j_nx_s)) : '0;
      B_Addr  <= issue_nx_s ? (base_nx_s + AW'(j_nx_s)) : '0;
      I_En    <= issue_nx_s;
      I_RW    <= 1'b0;
      C_Addr  <= write_nx_s ? blk_nx_s : '0;
      O_En    <= write_nx_s;
      O_RW    <= write_nx_s;
      SAD_Out <= write_nx_s ? sum_nx_s : '0;
      Busy    <= (state_nx_s != S_IDLE);
      Done    <= (state_nx_s == S_FIN);
    end
  end

`ifdef SAD_MINTRACK_EN
  // Smallest block SAD of the frame; ties keep the earlier block
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      Min_SAD <= '0;
      Min_Idx <= '0;
    end else if ((state_r == S_IDLE) && Go) begin
      Min_SAD <= '0;
      Min_Idx <= '0;
    end else if ((state_r == S_WRITE) && ((blk_r == '0) || (sum_r < Min_SAD))) begin
      Min_SAD <= sum_r;
      Min_Idx <= blk_r;
    end else begin
      Min_SAD <= Min_SAD;
      Min_Idx <= Min_Idx;
    end
  end
`endif

endmodule
